// File: rtl/vedic_mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier built from one shared 4x4 multiplier over four phases.
// Optional completed-operation counter enabled by defining VEDIC_MUL8_OPCNT_EN.
module vedic_mul8_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product,
    output logic        busy,
    output logic        done,
    output logic [7:0]  op_count
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] P0   = 3'd1;
    localparam logic [2:0] P1   = 3'd2;
    localparam logic [2:0] P2   = 3'd3;
    localparam logic [2:0] P3   = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [7:0]  opA_q, opA_d;
    logic [7:0]  opB_q, opB_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] product_q, product_d;

    logic [3:0]  mulA, mulB;
    logic [7:0]  partial;
    logic [15:0] partialShifted;
    logic [15:0] accSum;

    // The phase selects which operand nibbles feed the single 4x4 multiplier and its weight.
    always_comb begin
        mulA           = opA_q[3:0];
        mulB           = opB_q[3:0];
        case (state_q)
            P1: mulB = opB_q[7:4];
            P2: mulA = opA_q[7:4];
            P3: begin
                mulA = opA_q[7:4];
                mulB = opB_q[7:4];
            end
            default: ;
        endcase
    end

    assign partial = {4'd0, mulA} * {4'd0, mulB};

    always_comb begin
        partialShifted = {8'd0, partial};
        case (state_q)
            P1, P2:  partialShifted = {4'd0, partial, 4'd0};
            P3:      partialShifted = {partial, 8'd0};
            default: ;
        endcase
    end

    assign accSum = acc_q + partialShifted;

    always_comb begin
        state_d   = state_q;
        opA_d     = opA_q;
        opB_d     = opB_q;
        acc_d     = acc_q;
        product_d = product_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opA_d   = a;
                        opB_d   = b;
                        acc_d   = 16'd0;
                        state_d = P0;
                    end
                end
                P0, P1, P2: begin
                    acc_d   = accSum;
                    state_d = state_q + 3'd1;
                end
                P3: begin
                    acc_d     = accSum;
                    product_d = accSum;
                    state_d   = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opA_q     <= 8'd0;
            opB_q     <= 8'd0;
            acc_q     <= 16'd0;
            product_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

`ifdef VEDIC_MUL8_OPCNT_EN
    logic [7:0] opCount_q, opCount_d;

    // Counts each completion, wrapping naturally at 8 bits.
    always_comb begin
        opCount_d = opCount_q;
        if (ena && (state_q == P3)) begin
            opCount_d = opCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opCount_q <= 8'd0;
        end else begin
            opCount_q <= opCount_d;
        end
    end

    assign op_count = opCount_q;
`else
    assign op_count = 8'd0;
`endif

    assign product = product_q;
    assign busy    = (state_q == P0) || (state_q == P1) || (state_q == P2) || (state_q == P3);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_vedic_mul8_seq_ctrl.sv
// Self-checking bench for vedic_mul8_seq_ctrl: directed and random multiplies against a product = a*b model.
// Counter expectations follow VEDIC_MUL8_OPCNT_EN when it is defined for the build.
module tb_vedic_mul8_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        busy;
    logic        done;
    logic [7:0]  op_count;

    int          checks;
    int          errors;
    logic [15:0] expProduct;
    int          expCount;

    vedic_mul8_seq_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .start    (start),
        .a        (a),
        .b        (b),
        .product  (product),
        .busy     (busy),
        .done     (done),
        .op_count (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] expectedCount();
`ifdef VEDIC_MUL8_OPCNT_EN
        return 16'(expCount % 256);
`else
        return 16'd0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One multiply from the current negedge: x*y, optional start hold with operand churn,
    // and an optional ena stall after phase stallAt (0..3 busy phases, 4 = DONE).
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input bit hold,
                                 input int stallAt, input int stallLen);
        logic [15:0] want;
        want  = {8'd0, x} * {8'd0, y};
        a     = x;
        b     = y;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("busyPhase", {15'd0, busy}, 16'd1);
            checkOutput("doneLowBusy", {15'd0, done}, 16'd0);
            checkOutput("productHeld", product, expProduct);
            if (hold) begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
            end else begin
                start = 1'b0;
            end
            if (i == stallAt) begin
                ena = 1'b0;
                repeat (stallLen) begin
                    @(negedge clk);
                    checkOutput("stallBusy", {15'd0, busy}, 16'd1);
                    checkOutput("stallDone", {15'd0, done}, 16'd0);
                    checkOutput("stallProduct", product, expProduct);
                end
                ena = 1'b1;
            end
        end
        @(negedge clk);
        expProduct = want;
        expCount++;
        checkOutput("donePulse", {15'd0, done}, 16'd1);
        checkOutput("busyLowDone", {15'd0, busy}, 16'd0);
        checkOutput("product", product, expProduct);
        checkOutput("opCount", {8'd0, op_count}, expectedCount());
        if (stallAt == 4) begin
            ena = 1'b0;
            repeat (stallLen) begin
                @(negedge clk);
                checkOutput("frozenDone", {15'd0, done}, 16'd1);
                checkOutput("frozenProduct", product, expProduct);
            end
            ena = 1'b1;
        end
        @(negedge clk);
        checkOutput("idleDone", {15'd0, done}, 16'd0);
        checkOutput("idleBusy", {15'd0, busy}, 16'd0);
        checkOutput("idleProduct", product, expProduct);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        expProduct = 16'd0;
        expCount   = 0;
        rst_n      = 1'b0;
        ena        = 1'b1;
        start      = 1'b0;
        a          = 8'd0;
        b          = 8'd0;

        #2;
        checkOutput("resetProduct", product, 16'd0);
        checkOutput("resetBusy", {15'd0, busy}, 16'd0);
        checkOutput("resetDone", {15'd0, done}, 16'd0);
        checkOutput("resetOpCount", {8'd0, op_count}, 16'd0);

        // Start in the same cycle reset is released: first qualifying edge must accept.
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h03, 8'h02, 1'b0, -1, 0);
        applyStimulus(8'hFF, 8'hFF, 1'b0, -1, 0);
        applyStimulus(8'h12, 8'h34, 1'b0, -1, 0);
        applyStimulus(8'h09, 8'h00, 1'b0, -1, 0);

        // Start held high with operands changing while busy.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1, -1, 0);
        end
        start = 1'b0;
        @(negedge clk);

        // Reset in P2 of 0xFF*0xFF aborts without a result or done pulse.
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expProduct = 16'd0;
        expCount   = 0;
        checkOutput("abortProduct", product, 16'd0);
        checkOutput("abortBusy", {15'd0, busy}, 16'd0);
        checkOutput("abortDone", {15'd0, done}, 16'd0);
        checkOutput("abortOpCount", {8'd0, op_count}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("noDoneAfterAbort", {15'd0, done}, 16'd0);
            checkOutput("noBusyAfterAbort", {15'd0, busy}, 16'd0);
            checkOutput("productAfterAbort", product, 16'd0);
        end
        applyStimulus(8'h05, 8'h04, 1'b0, -1, 0);

        // ena stalls: three cycles during P1, then two cycles frozen in DONE.
        applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 1, 3);
        applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, 4, 2);

        // Fresh reset, then 257 random operations so the counter wraps to 1.
        rst_n = 1'b0;
        #1;
        expProduct = 16'd0;
        expCount   = 0;
        checkOutput("reResetOpCount", {8'd0, op_count}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 257; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, -1, 0);
        end
`ifdef VEDIC_MUL8_OPCNT_EN
        checkOutput("opCount257", {8'd0, op_count}, 16'd1);
`else
        checkOutput("opCount257", {8'd0, op_count}, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vedic_mul8_seq_ctrl.md
VEDIC_MUL8_SEQ_CTRL -- requirements
Module: vedic_mul8_seq_ctrl

Interface
REQ-001 Parameters SHALL be: none.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  global enable; low freezes all state.
REQ-005 start  input  1  request a new 8x8 multiply.
REQ-006 a  input  8  unsigned multiplicand.
REQ-007 b  input  8  unsigned multiplier.
REQ-008 product  output  16  registered result of last completed multiply.
REQ-009 busy  output  1  high while a multiply is in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 op_count  output  8  completed-operation counter (see Configuration).

Function
REQ-012 Block SHALL contain exactly one combinational 4x4 unsigned multiplier, time-shared across four phases.
REQ-013 FSM states SHALL be IDLE, P0 (aL*bL), P1 (aL*bH), P2 (aH*bL), P3 (aH*bH), DONE.
REQ-014 Start SHALL be accepted only at a rising edge with state=IDLE, ena=1, start=1: latch a and b, clear the 16-bit accumulator, go to P0.
REQ-015 start SHALL be ignored in P0..P3 and DONE; latched operands SHALL NOT change until the next acceptance.
REQ-016 At each edge in P0..P3 with ena=1, acc SHALL add the partial product shifted by 0, 4, 4 and 8 bits respectively, then advance P0->P1->P2->P3->DONE.
REQ-017 Accumulation SHALL be 16-bit unsigned; the final sum never exceeds 0xFE01, so no overflow handling is needed.
REQ-018 At the P3->DONE edge, product SHALL load the final sum; product SHALL hold its previous value during P0..P3.
REQ-019 busy SHALL be 1 exactly in states P0..P3.
REQ-020 done SHALL be 1 exactly in DONE; DONE SHALL return to IDLE at the next ena=1 edge.
REQ-021 Latency: with start sampled at edge k and ena held high, busy SHALL be high after edges k..k+3 and done high after edge k+4.
REQ-022 A back-to-back start SHALL be accepted no earlier than the edge at which DONE->IDLE occurs +1 (i.e. in IDLE).
REQ-023 ena=0 SHALL hold state, acc, operands, product, op_count and outputs unchanged; done remains high if frozen in DONE.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, product=0, busy=0, done=0, acc=0, operands=0, op_count=0.
REQ-025 Reset asserted mid-operation SHALL abort the multiply without updating product; no done pulse SHALL occur.
REQ-026 After rst_n rises, the first start SHALL be accepted at the first qualifying edge.

Configuration
REQ-027 Macro VEDIC_MUL8_OPCNT_EN SHALL control the operation counter.
REQ-028 Defined: op_count SHALL increment by 1 at each P3->DONE edge and wrap 255->0.
REQ-029 Not defined: op_count SHALL be constant 0 and no counter register SHALL be synthesized; all other behaviour SHALL be identical.

Verification
REQ-030 a=0x03, b=0x02, start pulse -> done after 5 edges, product=0x0006, busy high for exactly 4 cycles.
REQ-031 a=0xFF, b=0xFF -> product=0xFE01; then a=0x12, b=0x34 -> product=0x03A8; a=0x09, b=0x00 -> product=0x0000.
REQ-032 start held high continuously with a/b changing during busy -> results use operands latched at acceptance only; one operation per 6 cycles.
REQ-033 rst_n pulsed low during P2 of 0xFF*0xFF -> product=0, busy=0, no done; the next 0x05*0x04 yields 0x0014.
REQ-034 ena low for 3 cycles during P1 -> state frozen, done delayed by exactly 3 cycles, product correct.
REQ-035 With VEDIC_MUL8_OPCNT_EN, 257 operations -> op_count=1; without the macro -> op_count=0 throughout.
